// File: rtl/half_adder_pkg.sv
// Shared definitions for the registered half adder.
// Holds the default lane count and carry-counter width, plus a reference
// per-bit {carry,sum} function used by the lane cell.
package half_adder_pkg;

   localparam int HA_WIDTH_DEF = 1;
   localparam int HA_CNT_W_DEF = 16;

   // Returns {carry, sum}. This 2-bit value equals a_bit + b_bit.
   function automatic logic [1:0] ha_sum_carry(input logic a_bit, input logic b_bit);
      return {a_bit & b_bit, a_bit ^ b_bit};
   endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Purpose : single-bit combinational half adder (one lane).
// Latency : 0 cycles, purely combinational.
// Backpressure: none.
// Ports   : a, b (operand bits) -> sum = a ^ b, carry = a & b.
module half_adder_cell
   import half_adder_pkg::*;
(
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   assign {carry, sum} = ha_sum_carry(a, b);

endmodule

// File: rtl/half_adder.sv
// Purpose : registered, bit-parallel half adder with WIDTH independent lanes.
// Latency : 1 cycle from in_valid to out_valid.
// Backpressure: none; a valid input is accepted every cycle.
// Ports   : clk, rst (async, active-high), in_valid, a, b -> sum, carry, out_valid.
// Option  : define HALF_ADDER_STATS_EN to add stats_clr input, the CNT_W
//           parameter and a saturating carry_events counter output.
module half_adder
   import half_adder_pkg::*;
#(
   parameter int WIDTH = HA_WIDTH_DEF
`ifdef HALF_ADDER_STATS_EN
   ,
   parameter int CNT_W = HA_CNT_W_DEF
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef HALF_ADDER_STATS_EN
   input  logic             stats_clr,
   output logic [CNT_W-1:0] carry_events,
`endif
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry,
   output logic             out_valid
);

   logic [WIDTH-1:0] lane_sum;
   logic [WIDTH-1:0] lane_carry;

   logic [WIDTH-1:0] sum_d,   sum_q;
   logic [WIDTH-1:0] carry_d, carry_q;
   logic             out_valid_d, out_valid_q;

   // One independent half adder per lane; no carry chaining between lanes.
   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      half_adder_cell u_cell (
         .a     (a[i]),
         .b     (b[i]),
         .sum   (lane_sum[i]),
         .carry (lane_carry[i])
      );
   end

   // Results hold across idle cycles; only out_valid drops.
   always_comb begin
      sum_d       = sum_q;
      carry_d     = carry_q;
      out_valid_d = in_valid;
      if (in_valid) begin
         sum_d   = lane_sum;
         carry_d = lane_carry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q       <= '0;
         carry_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign sum       = sum_q;
   assign carry     = carry_q;
   assign out_valid = out_valid_q;

`ifdef HALF_ADDER_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] carry_events_d, carry_events_q;

   // Clear has priority over a counted event; the counter saturates at all-ones.
   always_comb begin
      carry_events_d = carry_events_q;
      if (stats_clr) begin
         carry_events_d = '0;
      end else if (in_valid && (|lane_carry) && (carry_events_q != CNT_MAX)) begin
         carry_events_d = carry_events_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         carry_events_q <= '0;
      end else begin
         carry_events_q <= carry_events_d;
      end
   end

   assign carry_events = carry_events_q;
`endif

endmodule

// File: tb/tb_half_adder.sv
module tb_half_adder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       v1 = 1'b0;
   logic       a1 = 1'b0;
   logic       b1 = 1'b0;
   logic       s1, c1, ov1;
   logic       v4 = 1'b0;
   logic [3:0] a4 = '0;
   logic [3:0] b4 = '0;
   logic [3:0] s4, c4;
   logic       ov4;

   int n_pass  = 0;
   int n_total = 0;

`ifdef HALF_ADDER_STATS_EN
   logic       clr1 = 1'b0;
   logic [1:0] ev1;
   logic [15:0] ev4;
`endif

   always #5 clk = ~clk;

   half_adder #(
      .WIDTH(1)
`ifdef HALF_ADDER_STATS_EN
      ,
      .CNT_W(2)
`endif
   ) u_dut1 (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (v1),
      .a            (a1),
      .b            (b1),
`ifdef HALF_ADDER_STATS_EN
      .stats_clr    (clr1),
      .carry_events (ev1),
`endif
      .sum          (s1),
      .carry        (c1),
      .out_valid    (ov1)
   );

   half_adder #(
      .WIDTH(4)
   ) u_dut4 (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (v4),
      .a            (a4),
      .b            (b4),
`ifdef HALF_ADDER_STATS_EN
      .stats_clr    (1'b0),
      .carry_events (ev4),
`endif
      .sum          (s4),
      .carry        (c4),
      .out_valid    (ov4)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Advance past the next rising edge and sample 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state.
      #12;
      check("rst_sum1",   16'(s1),  16'h0);
      check("rst_carry1", 16'(c1),  16'h0);
      check("rst_valid1", 16'(ov1), 16'h0);
      check("rst_sum4",   16'(s4),  16'h0);
      check("rst_carry4", 16'(c4),  16'h0);
      check("rst_valid4", 16'(ov4), 16'h0);
      rst = 1'b0;

      // Truth table at WIDTH=1, with the WIDTH=4 lanes exercised alongside.
      v1 = 1'b1; a1 = 1'b0; b1 = 1'b0;
      v4 = 1'b1; a4 = 4'b1100; b4 = 4'b1010;
      tick();
      check("tt00_sum",   16'(s1),  16'h0);
      check("tt00_carry", 16'(c1),  16'h0);
      check("tt00_valid", 16'(ov1), 16'h1);
      check("w4_sum",     16'(s4),  16'h6);
      check("w4_carry",   16'(c4),  16'h8);
      check("w4_valid",   16'(ov4), 16'h1);

      a1 = 1'b0; b1 = 1'b1;
      a4 = 4'hF; b4 = 4'hF;
      tick();
      check("tt01_sum",   16'(s1),  16'h1);
      check("tt01_carry", 16'(c1),  16'h0);
      check("tt01_valid", 16'(ov1), 16'h1);
      check("w4ff_sum",   16'(s4),  16'h0);
      check("w4ff_carry", 16'(c4),  16'hF);
      check("w4ff_valid", 16'(ov4), 16'h1);

      a1 = 1'b1; b1 = 1'b0;
      v4 = 1'b0; a4 = 4'b0101; b4 = 4'b0011;
      tick();
      check("tt10_sum",    16'(s1),  16'h1);
      check("tt10_carry",  16'(c1),  16'h0);
      check("w4hold_sum",  16'(s4),  16'h0);
      check("w4hold_carry",16'(c4),  16'hF);
      check("w4hold_valid",16'(ov4), 16'h0);

      a1 = 1'b1; b1 = 1'b1;
      tick();
      check("tt11_sum",   16'(s1),  16'h0);
      check("tt11_carry", 16'(c1),  16'h1);
      check("tt11_valid", 16'(ov1), 16'h1);

      // Hold: idle cycle with changed operands keeps the last result.
      v1 = 1'b0; a1 = 1'b0; b1 = 1'b1;
      tick();
      check("hold_sum",   16'(s1),  16'h0);
      check("hold_carry", 16'(c1),  16'h1);
      check("hold_valid", 16'(ov1), 16'h0);

      // Capture sum=1 so the async clear is visible, then reset mid-cycle.
      v1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
      tick();
      check("pre_rst_sum", 16'(s1), 16'h1);
      v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
      #2 rst = 1'b1;
      #1;
      check("arst_sum",   16'(s1),  16'h0);
      check("arst_carry", 16'(c1),  16'h0);
      check("arst_valid", 16'(ov1), 16'h0);

      // Reset held across an edge with a valid input: nothing captured.
      tick();
      check("rst_edge_carry", 16'(c1),  16'h0);
      check("rst_edge_valid", 16'(ov1), 16'h0);
      #2 rst = 1'b0;

      // First post-reset edge with no valid input: outputs remain 0.
      v1 = 1'b0;
      tick();
      check("post_rst_idle_carry", 16'(c1),  16'h0);
      check("post_rst_idle_valid", 16'(ov1), 16'h0);

      // Next valid input is captured normally.
      v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
      tick();
      check("post_rst_sum",   16'(s1),  16'h0);
      check("post_rst_carry", 16'(c1),  16'h1);
      check("post_rst_valid", 16'(ov1), 16'h1);

`ifdef HALF_ADDER_STATS_EN
      // Counter: clear via reset, then count and saturate at 3.
      v1 = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("ev_rst", 16'(ev1), 16'h0);
      #2 rst = 1'b0;
      v1 = 1'b1; a1 = 1'b1; b1 = 0;
      tick();
      check("ev_nocarry", 16'(ev1), 16'h0);
      a1 = 1'b1; b1 = 1'b1;
      tick(); check("ev_1", 16'(ev1), 16'h1);
      tick(); check("ev_2", 16'(ev1), 16'h2);
      tick(); check("ev_3", 16'(ev1), 16'h3);
      tick(); check("ev_sat4", 16'(ev1), 16'h3);
      tick(); check("ev_sat5", 16'(ev1), 16'h3);
      clr1 = 1'b1;
      tick(); check("ev_clr_wins", 16'(ev1), 16'h0);
      clr1 = 1'b0;
      v1 = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
